// File: rtl/sfx_scheduler_pkg.sv
// music_pkg: note codes, origin constants, effect tables and scheduler types
// Note codes are {high,med,low} nibbles; E0 (all zero) is a rest.
package music_pkg;
  localparam int NUM_FX = 3;
  localparam int FX_LEN = 4;
  localparam int NOTE_W = 12;
  localparam int ORG_W = 14;
  localparam int STEP_W = $clog2(FX_LEN);
  localparam logic [ORG_W-1:0] NOTE_SILENT = 14'd16383;
  localparam logic [NOTE_W-1:0] E0 = 12'h000;
  localparam logic [NOTE_W-1:0] L1 = 12'h001, L2 = 12'h002, L3 = 12'h003, L4 = 12'h004,
                                L5 = 12'h005, L6 = 12'h006, L7 = 12'h007;
  localparam logic [NOTE_W-1:0] M1 = 12'h010, M2 = 12'h020, M3 = 12'h030, M4 = 12'h040,
                                M5 = 12'h050, M6 = 12'h060, M7 = 12'h070;
  localparam logic [NOTE_W-1:0] H1 = 12'h100, H2 = 12'h200, H3 = 12'h300, H4 = 12'h400,
                                H5 = 12'h500, H6 = 12'h600, H7 = 12'h700;
  // Index 0 holds degree 1 of each octave.
  localparam logic [6:0][ORG_W-1:0] ORG_L = {14'd10310, 14'd9565, 14'd8730, 14'd7787,
                                             14'd7292, 14'd6179, 14'd4933};
  localparam logic [6:0][ORG_W-1:0] ORG_M = {14'd13347, 14'd12974, 14'd12556, 14'd12085,
                                             14'd11831, 14'd11272, 14'd10647};
  localparam logic [6:0][ORG_W-1:0] ORG_H = {14'd14858, 14'd14678, 14'd14470, 14'd14236,
                                             14'd14107, 14'd13830, 14'd13515};
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BGM = 2'd1, S_FX = 2'd2} state_e;
  // Fixed effect tables: fx0 wall bounce, fx1 paddle hit, fx2 miss.
  function automatic logic [NOTE_W-1:0] fx_note(input logic [1:0] fx, input logic [STEP_W-1:0] step);
    case (fx)
      2'd0: return step < 2'd2 ? M5 : E0;
      2'd1: return step == 2'd0 ? H1 : step == 2'd1 ? H3 : step == 2'd2 ? H5 : E0;
      default: return step == 2'd0 ? M3 : step == 2'd1 ? M2 : step == 2'd2 ? M1 : L5;
    endcase
  endfunction
endpackage

// File: rtl/sfx_scheduler_if.sv
// sfx_scheduler_if: note-scheduler bus between music/effect sources and the tone generator
// master drives tick, bgm_note, fx_req, mute; slave (scheduler) drives bgm_ack, note,
// origin, active_src, fx_busy.
interface sfx_scheduler_if;
  import music_pkg::*;
  logic tick;
  logic [NOTE_W-1:0] bgm_note;
  logic bgm_ack;
  logic [NUM_FX-1:0] fx_req;
  logic mute;
  logic [NOTE_W-1:0] note;
  logic [ORG_W-1:0] origin;
  logic [1:0] active_src;
  logic fx_busy;
  modport master (output tick, bgm_note, fx_req, mute,
                  input bgm_ack, note, origin, active_src, fx_busy);
  modport slave (input tick, bgm_note, fx_req, mute,
                 output bgm_ack, note, origin, active_src, fx_busy);
endinterface

// File: rtl/sfx_scheduler_note_origin_lut.sv
// note_origin_lut: combinational note code to tone-divider preload map
// code_i: 12-bit {high,med,low} note code; origin_o: 14-bit preload, silent for E0/unlisted.
module note_origin_lut
  import music_pkg::*;
(
  input  logic [NOTE_W-1:0] code_i,
  output logic [ORG_W-1:0]  origin_o
);
  always_comb
    case (code_i)
      L1: origin_o = ORG_L[0];
      L2: origin_o = ORG_L[1];
      L3: origin_o = ORG_L[2];
      L4: origin_o = ORG_L[3];
      L5: origin_o = ORG_L[4];
      L6: origin_o = ORG_L[5];
      L7: origin_o = ORG_L[6];
      M1: origin_o = ORG_M[0];
      M2: origin_o = ORG_M[1];
      M3: origin_o = ORG_M[2];
      M4: origin_o = ORG_M[3];
      M5: origin_o = ORG_M[4];
      M6: origin_o = ORG_M[5];
      M7: origin_o = ORG_M[6];
      H1: origin_o = ORG_H[0];
      H2: origin_o = ORG_H[1];
      H3: origin_o = ORG_H[2];
      H4: origin_o = ORG_H[3];
      H5: origin_o = ORG_H[4];
      H6: origin_o = ORG_H[5];
      H7: origin_o = ORG_H[6];
      default: origin_o = NOTE_SILENT;
    endcase
endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: shares the tone generator between background music and three sound effects
// clock/rst_n: system clock, async active-low reset; bus: sfx_scheduler_if slave
// (tick, bgm_note, fx_req, mute in; bgm_ack, note, origin, active_src, fx_busy out).
module sfx_scheduler
  import music_pkg::*;
(
  input logic clock,
  input logic rst_n,
  sfx_scheduler_if.slave bus
);
  state_e state_q, state_d;
  logic [NUM_FX-1:0] pend_q, pend_d, pend_eff;
  logic [1:0] cur_q, cur_d, top_idx;
  logic [STEP_W-1:0] step_q, step_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [ORG_W-1:0] origin_q, origin_d, lut_origin;
  logic ack_q, ack_d;
  logic launch_ok, go_fx, go_bgm, advance;
  // Requests arriving with the tick join that tick's decision.
  assign pend_eff = pend_q | bus.fx_req;
  assign top_idx = pend_eff[2] ? 2'd2 : pend_eff[1] ? 2'd1 : 2'd0;
  assign launch_ok = state_q != S_FX || step_q == STEP_W'(FX_LEN - 1);
  // Only a strictly higher index may cut into a running effect.
  assign go_fx = bus.tick && |pend_eff && (launch_ok || top_idx > cur_q);
  assign go_bgm = bus.tick && !(|pend_eff) && launch_ok;
  assign advance = bus.tick && state_q == S_FX && !go_fx && !go_bgm;
  always_comb begin
    state_d = go_fx ? S_FX : go_bgm ? S_BGM : state_q;
    cur_d = go_fx ? top_idx : cur_q;
    step_d = go_fx ? '0 : advance ? step_q + 2'd1 : step_q;
    note_d = go_fx ? fx_note(top_idx, '0) : go_bgm ? bus.bgm_note :
             advance ? fx_note(cur_q, step_q + 2'd1) : note_q;
    pend_d = go_fx ? pend_eff & ~(NUM_FX'(1) << top_idx) : pend_eff;
    origin_d = bus.mute ? NOTE_SILENT : lut_origin;
    ack_d = go_bgm;
  end
  note_origin_lut u_lut (.code_i(note_d), .origin_o(lut_origin));
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q <= '0;
      cur_q <= '0;
      step_q <= '0;
      note_q <= E0;
      origin_q <= NOTE_SILENT;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      cur_q <= cur_d;
      step_q <= step_d;
      note_q <= note_d;
      origin_q <= origin_d;
      ack_q <= ack_d;
    end
  assign bus.note = note_q;
  assign bus.origin = origin_q;
  assign bus.bgm_ack = ack_q;
  assign bus.active_src = state_q;
  assign bus.fx_busy = state_q == S_FX;
endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: directed self-checking bench for sfx_scheduler
module tb_sfx_scheduler;
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  sfx_scheduler_if bus ();
  sfx_scheduler dut (.clock(clock), .rst_n(rst_n), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic [11:0] n, input logic [13:0] o,
                            input logic [1:0] s, input logic a);
    chk({tag, " note"}, 32'(bus.note), 32'(n));
    chk({tag, " origin"}, 32'(bus.origin), 32'(o));
    chk({tag, " src"}, 32'(bus.active_src), 32'(s));
    chk({tag, " busy"}, 32'(bus.fx_busy), 32'(s == 2'd2));
    chk({tag, " ack"}, 32'(bus.bgm_ack), 32'(a));
  endtask
  task automatic tick_once(input logic [2:0] req);
    @(negedge clock);
    bus.tick = 1'b1;
    bus.fx_req = req;
    @(posedge clock);
    #1;
    bus.tick = 1'b0;
    bus.fx_req = 3'b000;
  endtask
  task automatic pulse(input logic [2:0] req);
    @(negedge clock);
    bus.fx_req = req;
    @(posedge clock);
    #1;
    bus.fx_req = 3'b000;
  endtask
  task automatic idle();
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask
  task automatic fx_step(input string tag, input logic [11:0] n, input logic [13:0] o);
    tick_once(3'b000);
    expect_out(tag, n, o, 2'd2, 1'b0);
  endtask
  task automatic set_mute(input logic m);
    @(negedge clock);
    bus.mute = m;
    @(posedge clock);
    #1;
  endtask
  initial begin
    bus.tick = 1'b0;
    bus.fx_req = 3'b000;
    bus.mute = 1'b0;
    bus.bgm_note = 12'h000;
    repeat (2) @(posedge clock);
    #1;
    expect_out("reset", 12'h000, 14'd16383, 2'd0, 1'b0);
    @(negedge clock) rst_n = 1'b1;
    bus.bgm_note = 12'h060;
    tick_once(3'b000);
    expect_out("bgm_m6", 12'h060, 14'd12974, 2'd1, 1'b1);
    idle();
    chk("bgm_ack_drop", 32'(bus.bgm_ack), 32'd0);
    chk("bgm_hold_note", 32'(bus.note), 32'h060);
    pulse(3'b010);
    fx_step("fx1_s0", 12'h100, 14'd13515);
    fx_step("fx1_s1", 12'h300, 14'd14107);
    fx_step("fx1_s2", 12'h500, 14'd14470);
    fx_step("fx1_s3", 12'h000, 14'd16383);
    tick_once(3'b000);
    expect_out("fx1_resume", 12'h060, 14'd12974, 2'd1, 1'b1);
    pulse(3'b001);
    fx_step("fx0_s0", 12'h050, 14'd12556);
    fx_step("fx0_s1", 12'h050, 14'd12556);
    pulse(3'b100);
    fx_step("pre_fx2_s0", 12'h030, 14'd11831);
    fx_step("pre_fx2_s1", 12'h020, 14'd11272);
    fx_step("pre_fx2_s2", 12'h010, 14'd10647);
    fx_step("pre_fx2_s3", 12'h005, 14'd8730);
    bus.bgm_note = 12'h001;
    tick_once(3'b000);
    expect_out("pre_no_fx0", 12'h001, 14'd4933, 2'd1, 1'b1);
    tick_once(3'b011);
    expect_out("dual_fx1_s0", 12'h100, 14'd13515, 2'd2, 1'b0);
    fx_step("dual_fx1_s1", 12'h300, 14'd14107);
    fx_step("dual_fx1_s2", 12'h500, 14'd14470);
    fx_step("dual_fx1_s3", 12'h000, 14'd16383);
    fx_step("dual_fx0_s0", 12'h050, 14'd12556);
    fx_step("dual_fx0_s1", 12'h050, 14'd12556);
    fx_step("dual_fx0_s2", 12'h000, 14'd16383);
    fx_step("dual_fx0_s3", 12'h000, 14'd16383);
    tick_once(3'b000);
    expect_out("dual_bgm", 12'h001, 14'd4933, 2'd1, 1'b1);
    tick_once(3'b010);
    expect_out("rep_s0", 12'h100, 14'd13515, 2'd2, 1'b0);
    pulse(3'b010);
    pulse(3'b010);
    fx_step("rep_s1", 12'h300, 14'd14107);
    fx_step("rep_s2", 12'h500, 14'd14470);
    fx_step("rep_s3", 12'h000, 14'd16383);
    fx_step("rep_again_s0", 12'h100, 14'd13515);
    fx_step("rep_again_s1", 12'h300, 14'd14107);
    fx_step("rep_again_s2", 12'h500, 14'd14470);
    fx_step("rep_again_s3", 12'h000, 14'd16383);
    tick_once(3'b000);
    expect_out("rep_once", 12'h001, 14'd4933, 2'd1, 1'b1);
    bus.bgm_note = 12'h300;
    tick_once(3'b000);
    expect_out("mute_pre", 12'h300, 14'd14107, 2'd1, 1'b1);
    set_mute(1'b1);
    expect_out("mute_on", 12'h300, 14'd16383, 2'd1, 1'b0);
    set_mute(1'b0);
    expect_out("mute_off", 12'h300, 14'd14107, 2'd1, 1'b0);
    bus.bgm_note = 12'h011;
    tick_once(3'b000);
    expect_out("unlisted_011", 12'h011, 14'd16383, 2'd1, 1'b1);
    bus.bgm_note = 12'h008;
    tick_once(3'b000);
    expect_out("unlisted_008", 12'h008, 14'd16383, 2'd1, 1'b1);
    bus.bgm_note = 12'h700;
    tick_once(3'b000);
    expect_out("bgm_h7", 12'h700, 14'd14858, 2'd1, 1'b1);
    tick_once(3'b100);
    expect_out("rst_fx2_s0", 12'h030, 14'd11831, 2'd2, 1'b0);
    fx_step("rst_fx2_s1", 12'h020, 14'd11272);
    fx_step("rst_fx2_s2", 12'h010, 14'd10647);
    pulse(3'b001);
    @(negedge clock) rst_n = 1'b0;
    #1;
    expect_out("rst_mid", 12'h000, 14'd16383, 2'd0, 1'b0);
    @(negedge clock) rst_n = 1'b1;
    bus.bgm_note = 12'h007;
    tick_once(3'b000);
    expect_out("rst_bgm1", 12'h007, 14'd10310, 2'd1, 1'b1);
    tick_once(3'b000);
    expect_out("rst_bgm2", 12'h007, 14'd10310, 2'd1, 1'b1);
    idle();
    chk("rst_end_ack", 32'(bus.bgm_ack), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
